matrix_alu_seq: RTL

Sequential matrix arithmetic unit: the responder side of the coprocessor's `start` / `process_Done` handshake. It sits between the coprocessor FSM and nothing else. On a start request it latches two packed 5x5 signed-byte matrices plus the op code, size and scalar, and computes the result one element per cycle (element-wise ops) or one product per cycle (matrix multiply). It then holds `process_Done` and the packed result until the controller drops `start`.

---
 rtl/matrix_alu_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_alu_seq.sv
// Sequential 5x5 signed-byte matrix ALU: latches operands on start, computes one
// element (or one multiply-accumulate step) per cycle, then holds the result until start drops.
module matrix_alu_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op_code,
  input  logic [1:0]   matrix_size,
  input  logic [199:0] matrix_a,
  input  logic [199:0] matrix_b,
  input  logic [7:0]   scalar,
  output logic [199:0] result_final,
  output logic         overflow,
  output logic         process_Done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SCL = 3'd3;
  localparam logic [2:0] OP_TRN = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;

  function automatic logic [7:0] bit_base(input logic [2:0] r, input logic [2:0] c);
    logic [7:0] idx;
    idx = {5'd0, r} * 8'd5 + {5'd0, c};
    return {idx[4:0], 3'b000};
  endfunction

  function automatic logic [7:0] get_elem(input logic [199:0] m, input logic [2:0] r,
                                          input logic [2:0] c);
    return m[bit_base(r, c) +: 8];
  endfunction

  function automatic logic signed [19:0] sx8(input logic [7:0] v);
    return {{12{v[7]}}, v};
  endfunction

  function automatic logic signed [19:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] p;
    p = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
    return {{4{p[15]}}, p};
  endfunction

  function automatic logic out_of_s8(input logic signed [19:0] v);
    return (v > 20'sd127) || (v < -20'sd128);
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2:0]           n_q, n_d;
  logic [199:0]         a_q, a_d;
  logic [199:0]         b_q, b_d;
  logic [7:0]           scalar_q, scalar_d;
  logic [2:0]           i_q, i_d;
  logic [2:0]           j_q, j_d;
  logic [2:0]           k_q, k_d;
  logic signed [19:0]   acc_q, acc_d;
  logic [199:0]         result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic signed [19:0]   ew_full;
  logic signed [19:0]   mac_sum;
  logic                 in_range;
  logic [2:0]           last_idx;

  // Element-wise value at (i,j) and the multiply-accumulate step, both at full precision.
  always_comb begin
    ew_full  = 20'sd0;
    in_range = (i_q < n_q) && (j_q < n_q);
    last_idx = n_q - 3'd1;
    mac_sum  = ((k_q == 3'd0) ? 20'sd0 : acc_q)
               + mul8(get_elem(a_q, i_q, k_q), get_elem(b_q, k_q, j_q));
    case (op_q)
      OP_ADD:  ew_full = sx8(get_elem(a_q, i_q, j_q)) + sx8(get_elem(b_q, i_q, j_q));
      OP_SUB:  ew_full = sx8(get_elem(a_q, i_q, j_q)) - sx8(get_elem(b_q, i_q, j_q));
      OP_SCL:  ew_full = mul8(get_elem(a_q, i_q, j_q), scalar_q);
      OP_TRN:  ew_full = sx8(get_elem(a_q, j_q, i_q));
      OP_NEG:  ew_full = -sx8(get_elem(a_q, i_q, j_q));
      default: ew_full = 20'sd0;
    endcase
  end

  // Next-state, counter and result update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          op_d     = op_code;
          n_d      = {1'b0, matrix_size} + 3'd2;
          a_d      = matrix_a;
          b_d      = matrix_b;
          scalar_d = scalar;
          i_d      = 3'd0;
          j_d      = 3'd0;
          k_d      = 3'd0;
          acc_d    = 20'sd0;
          result_d = 200'd0;
          ovf_d    = 1'b0;
          state_d  = ST_COMPUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (op_q == OP_MUL) begin
          // Product walk over the NxN window only; the rest keeps the launch-time zeros.
          acc_d = mac_sum;
          if (k_q == last_idx) begin
            result_d[bit_base(i_q, j_q) +: 8] = mac_sum[7:0];
            ovf_d = ovf_q | out_of_s8(mac_sum);
            k_d   = 3'd0;
            if (j_q == last_idx) begin
              j_d = 3'd0;
              if (i_q == last_idx) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                i_d = i_q + 3'd1;
              end
            end else begin
              j_d = j_q + 3'd1;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end else begin
          // Element-wise ops sweep all 25 positions so latency does not depend on N.
          if (in_range) begin
            result_d[bit_base(i_q, j_q) +: 8] = ew_full[7:0];
            ovf_d = ovf_q | out_of_s8(ew_full);
          end else begin
            result_d[bit_base(i_q, j_q) +: 8] = 8'd0;
          end
          if (j_q == 3'd4) begin
            j_d = 3'd0;
            if (i_q == 3'd4) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              i_d = i_q + 3'd1;
            end
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, operand and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      n_q      <= 3'd2;
      a_q      <= 200'd0;
      b_q      <= 200'd0;
      scalar_q <= 8'd0;
      i_q      <= 3'd0;
      j_q      <= 3'd0;
      k_q      <= 3'd0;
      acc_q    <= 20'sd0;
      result_q <= 200'd0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result_final = result_q;
  assign overflow     = ovf_q;
  assign process_Done = done_q;

endmodule
